// File: rtl/fp8_pkg.sv
// Shared FP8 E4M3 definitions: width, the fp8 type and the special encodings.
package fp8_pkg;

  localparam int FP8_W = 8;

  typedef logic [FP8_W-1:0] fp8_t;

  localparam fp8_t       FP8_NAN     = 8'h7F;
  localparam logic [6:0] FP8_MAX_MAG = 7'h7E;

  // E4M3 has a single NaN magnitude (all exponent and mantissa bits set).
  function automatic logic fp8_is_nan(input fp8_t x);
    return (x[6:0] == FP8_NAN[6:0]);
  endfunction

endpackage

// File: rtl/fp8_e4m3_adder.sv
// Combinational FP8 E4M3 adder: exact fixed-point sum, round-to-nearest-even,
// saturation to +/-max on overflow, NaN propagation and +0 for exact zero.
module fp8_e4m3_adder
  import fp8_pkg::*;
(
  input  fp8_t i_a,
  input  fp8_t i_b,
  output fp8_t o_sum
);

  // Every E4M3 magnitude is an integer multiple of 2^-9 and fits in 18 bits.
  function automatic logic [17:0] fp8_to_fixed(input fp8_t x);
    logic [3:0] sig;
    logic [3:0] shamt;
    sig   = (x[6:3] == 4'd0) ? {1'b0, x[2:0]} : {1'b1, x[2:0]};
    shamt = (x[6:3] == 4'd0) ? 4'd0 : x[6:3] - 4'd1;
    return 18'(sig) << shamt;
  endfunction

  logic signed [19:0] w_val_a;
  logic signed [19:0] w_val_b;
  logic signed [19:0] w_total;
  logic        [18:0] w_abs;
  logic        [18:0] w_mask;
  logic        [4:0]  w_msb;
  logic        [4:0]  w_sh;
  logic        [3:0]  w_kept;
  logic               w_guard;
  logic               w_sticky;
  logic               w_rnd;
  logic        [8:0]  w_code;

  always_comb begin
    w_val_a  = $signed({2'b00, fp8_to_fixed(i_a)});
    w_val_b  = $signed({2'b00, fp8_to_fixed(i_b)});
    if (i_a[7]) w_val_a = -w_val_a;
    if (i_b[7]) w_val_b = -w_val_b;
    w_total  = w_val_a + w_val_b;
    w_abs    = w_total[19] ? 19'(-w_total) : w_total[18:0];

    w_msb = 5'd0;
    for (int k = 0; k < 19; k++) begin
      if (w_abs[k]) w_msb = 5'(k);
    end

    w_sh     = 5'd0;
    w_kept   = 4'd0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_mask   = '0;
    w_rnd    = 1'b0;
    // Below 16 units the value is exactly representable (subnormal or exp=1).
    if (w_msb < 5'd4) begin
      w_code = 9'(w_abs);
    end else begin
      w_sh     = w_msb - 5'd3;
      w_kept   = 4'(w_abs >> w_sh);
      w_guard  = w_abs[w_sh - 5'd1];
      w_mask   = (19'd1 << (w_sh - 5'd1)) - 19'd1;
      w_sticky = |(w_abs & w_mask);
      w_rnd    = w_guard && (w_sticky || w_kept[0]);
      w_code   = 9'({w_sh, 3'b000}) + 9'(w_kept) + 9'(w_rnd);
    end
    if (w_code > 9'(FP8_MAX_MAG)) w_code = 9'(FP8_MAX_MAG);

    if (fp8_is_nan(i_a) || fp8_is_nan(i_b)) begin
      o_sum = FP8_NAN;
    end else if (w_abs == '0) begin
      o_sum = 8'h00;
    end else begin
      o_sum = {w_total[19], w_code[6:0]};
    end
  end

endmodule

// File: rtl/fp8_add_arbiter.sv
// Round-robin arbiter sharing one FP8 E4M3 adder among NUM_REQ requesters,
// with a single registered output slot and an accepted-operation counter.
module fp8_add_arbiter
  import fp8_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [FP8_W*NUM_REQ-1:0] req_a,
  input  logic [FP8_W*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [FP8_W-1:0]         rsp_sum,
  output logic [ID_W-1:0]          rsp_id,
  output logic [CNT_W-1:0]         ops_count
);

  fp8_t            w_op_a [NUM_REQ];
  fp8_t            w_op_b [NUM_REQ];
  fp8_t            w_in_a;
  fp8_t            w_in_b;
  fp8_t            w_sum;
  logic            w_found;
  logic [ID_W-1:0] w_gnt;
  logic            w_slot_free;
  logic            w_xfer;

  logic            r_rsp_valid;
  fp8_t            r_rsp_sum;
  logic [ID_W-1:0] r_rsp_id;
  logic [ID_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_ops_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_op_a[gi] = req_a[FP8_W*gi +: FP8_W];
      assign w_op_b[gi] = req_b[FP8_W*gi +: FP8_W];
    end
  endgenerate

  // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
  always_comb begin : grant_comb
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'(idx);
      end
    end
  end

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_xfer      = w_found && w_slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt] = 1'b1;
  end

  assign w_in_a = w_op_a[w_gnt];
  assign w_in_b = w_op_b[w_gnt];

  fp8_e4m3_adder u_adder (
    .i_a   (w_in_a),
    .i_b   (w_in_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 8'h00;
      r_rsp_id    <= '0;
      r_ptr       <= '0;
      r_ops_cnt   <= '0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= w_sum;
      r_rsp_id    <= w_gnt;
      r_ptr       <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
      r_ops_cnt   <= r_ops_cnt + CNT_W'(1);
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign ops_count = r_ops_cnt;

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Scoreboard bench: the driver predicts grants and sums from a real-valued
// FP8 model and queues them; a negedge monitor compares the response slot.
module tb_fp8_add_arbiter;

  localparam int N        = 4;
  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [8*N-1:0]      req_a;
  logic [8*N-1:0]      req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [7:0]          rsp_sum;
  logic [1:0]          rsp_id;
  logic [TB_CNT_W-1:0] ops_count;

  fp8_add_arbiter #(.NUM_REQ(N), .CNT_W(TB_CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .ops_count (ops_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sum;
    int         id;
  } exp_t;

  exp_t                exp_q[$];
  int                  checks = 0;
  int                  errors = 0;
  int                  m_ptr  = 0;
  bit                  m_full = 1'b0;
  logic [TB_CNT_W-1:0] m_cnt  = '0;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real dec_mag(input logic [6:0] c);
    int e;
    int m;
    e = int'(c[6:3]);
    m = int'(c[2:0]);
    if (e == 0) return m * pow2(-9);
    return (1.0 + m / 8.0) * pow2(e - 7);
  endfunction

  // Real sum, then nearest representable magnitude, ties to even code.
  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    real  s, mag, d, bestd;
    int   best;
    logic sgn;
    if (a[6:0] == 7'h7F || b[6:0] == 7'h7F) return 8'h7F;
    s = (a[7] ? -1.0 : 1.0) * dec_mag(a[6:0]) + (b[7] ? -1.0 : 1.0) * dec_mag(b[6:0]);
    if (s == 0.0) return 8'h00;
    sgn = (s < 0.0);
    mag = sgn ? -s : s;
    if (mag >= 448.0) return {sgn, 7'h7E};
    best  = 0;
    bestd = mag;
    for (int c = 1; c <= 126; c++) begin
      d = mag - dec_mag(7'(c));
      if (d < 0.0) d = -d;
      if (d < bestd || (d == bestd && (c % 2) == 0)) begin
        best  = c;
        bestd = d;
      end
    end
    return {sgn, 7'(best)};
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; covers one full clock cycle.
  task automatic drive_cycle(input logic r, input logic [N-1:0] v,
                             input logic [8*N-1:0] a, input logic [8*N-1:0] b,
                             input logic rr, output int gnt);
    exp_t e;
    rst       = r;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
    gnt       = -1;
    if (!r && (!m_full || rr)) gnt = rr_pick(m_ptr, v);
    @(negedge clk);
    chk("req_ready", int'(req_ready), (gnt >= 0) ? (1 << gnt) : 0);
    chk("ops_count", int'(ops_count), int'(m_cnt));
    @(posedge clk);
    if (r) begin
      m_ptr  = 0;
      m_cnt  = '0;
      m_full = 1'b0;
      exp_q.delete();
    end else if (gnt >= 0) begin
      e.sum = ref_add(a[8*gnt +: 8], b[8*gnt +: 8]);
      e.id  = gnt;
      exp_q.push_back(e);
      m_ptr  = (gnt + 1) % N;
      m_cnt  = m_cnt + 1'b1;
      m_full = 1'b1;
    end else if (rr) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_sum", int'(rsp_sum), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_ops_count", int'(ops_count), 0);
  endtask

  always @(negedge clk) begin
    chk("rsp_valid", int'(rsp_valid), int'(exp_q.size() != 0));
    if (rsp_valid && exp_q.size() != 0) begin
      chk("rsp_sum", int'(rsp_sum), int'(exp_q[0].sum));
      chk("rsp_id", int'(rsp_id), exp_q[0].id);
      if (rsp_ready) begin
        $display("rsp id=%0d sum=%02h count=%0d", rsp_id, rsp_sum, ops_count);
        void'(exp_q.pop_front());
      end
    end
  end

  localparam logic [8*N-1:0] ALL38 = {N{8'h38}};
  localparam logic [8*N-1:0] ZERO  = '0;

  logic [7:0]     ca [8] = '{8'h7F, 8'h7E, 8'hFE, 8'h38, 8'h80, 8'h01, 8'h07, 8'hFF};
  logic [7:0]     cb [8] = '{8'h38, 8'h7E, 8'hFE, 8'hB8, 8'h80, 8'h01, 8'h01, 8'h10};
  logic [N-1:0]   p_v;
  logic [8*N-1:0] p_a;
  logic [8*N-1:0] p_b;
  int             g;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset state, then a single request on port 2
    repeat (2) drive_cycle(1'b1, '0, ZERO, ZERO, 1'b1, g);
    check_reset_state();
    drive_cycle(1'b0, 4'b0100, ALL38, ALL38, 1'b1, g);
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);

    // All ports requesting from reset: back-to-back grants 0,1,2,3,0
    drive_cycle(1'b1, '0, ZERO, ZERO, 1'b1, g);
    repeat (5) drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b1, g);
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);

    // Back-pressure: hold the result for 3 cycles, then drain and regrant
    drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b1, g);
    repeat (3) drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b0, g);
    drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b1, g);
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);

    // Arithmetic corners
    for (int k = 0; k < 8; k++) begin
      drive_cycle(1'b0, 4'(1 << (k % N)), {N{ca[k]}}, {N{cb[k]}}, 1'b1, g);
    end
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);

    // Reset while a result is pending and ptr=3
    drive_cycle(1'b1, '0, ZERO, ZERO, 1'b1, g);
    drive_cycle(1'b0, 4'b0100, ALL38, ALL38, 1'b0, g);
    drive_cycle(1'b1, 4'hF, ALL38, ALL38, 1'b0, g);
    check_reset_state();
    drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b1, g);
    chk("post_rst_grant", g, 0);
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);

    // Counter wrap: 17 operations on a 4-bit counter
    drive_cycle(1'b1, '0, ZERO, ZERO, 1'b1, g);
    repeat (17) drive_cycle(1'b0, 4'hF, ALL38, ALL38, 1'b1, g);
    drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);
    chk("ops_count_wrap", int'(ops_count), 1);

    // Random traffic with requesters holding until accepted
    p_v = '0; p_a = '0; p_b = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_v[i] && $urandom_range(0, 99) < 60) begin
          p_v[i]         = 1'b1;
          p_a[8*i +: 8]  = 8'($urandom);
          p_b[8*i +: 8]  = 8'($urandom);
        end
      end
      drive_cycle(($urandom_range(0, 99) == 0), p_v, p_a, p_b,
                  ($urandom_range(0, 3) != 0), g);
      if (g >= 0) p_v[g] = 1'b0;
    end

    repeat (3) drive_cycle(1'b0, '0, ZERO, ZERO, 1'b1, g);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
